// File: rtl/shift_counter_pkg.sv
// shift_counter_pkg: mode/direction encodings plus width-generic seed and step helpers
package shift_counter_pkg;
  localparam int MAX_W = 64;
  localparam logic MODE_RING = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic logic [MAX_W-1:0] seed(input logic mode);
    return mode == MODE_JOHNSON ? '0 : MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] step(input logic [MAX_W-1:0] c, input int w, input logic mode, input logic dir);
    logic [MAX_W-1:0] hi, mask;
    hi = c >> (w - 1);
    mask = (MAX_W'(1) << w) - MAX_W'(1);
    return mask & (dir == DIR_DOWN ? (c >> 1) | (MAX_W'(c[0] ^ mode) << (w - 1))
                                   : (c << 1) | MAX_W'(hi[0] ^ mode));
  endfunction
endpackage

// File: rtl/shift_counter_decode.sv
// shift_counter_decode: legality check and step-index decode of the counter register
module shift_counter_decode
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int PW = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] count_out,
  input  logic             mode_q,
  output logic             legal,
  output logic [PW-1:0]    position
);
  logic [PW-1:0] ring_pos, john_pos;
  always_comb begin
    ring_pos = '0;
    for (int i = 0; i < WIDTH; i++) if (count_out[i]) ring_pos = PW'(i);
    john_pos = count_out[WIDTH-1] ? PW'(2 * WIDTH - $countones(count_out)) : PW'($countones(count_out));
    legal = mode_q == MODE_JOHNSON ? ($countones(count_out[WIDTH-1:1] ^ count_out[WIDTH-2:0]) <= 1)
                                   : $onehot(count_out);
    position = legal ? (mode_q == MODE_JOHNSON ? john_pos : ring_pos) : '0;
  end
endmodule

// File: rtl/shift_counter.sv
// shift_counter: ring/Johnson shift counter with load, self-correction, position decode and wrap pulse
module shift_counter
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int PW = $clog2(2 * WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Mode,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_value,
  output logic [WIDTH-1:0] Count_out,
  output logic [PW-1:0]    Position,
  output logic             Wrap,
  output logic             Illegal
);
  logic [WIDTH-1:0] count_q, count_d;
  logic mode_q, mode_d, wrap_q, wrap_d, illegal_q, illegal_d, legal;
  logic [PW-1:0] last_pos;

  shift_counter_decode #(.WIDTH(WIDTH)) u_decode (
    .count_out(count_q),
    .mode_q   (mode_q),
    .legal    (legal),
    .position (Position)
  );

  assign last_pos = mode_q == MODE_JOHNSON ? PW'(2 * WIDTH - 1) : PW'(WIDTH - 1);

  always_comb begin
    count_d = count_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    illegal_d = 1'b0;
    if (Load) begin
      count_d = Load_value;
    end else if (Mode != mode_q) begin
      count_d = WIDTH'(seed(Mode));
      mode_d = Mode;
    end else if (Enable && !legal) begin
      count_d = WIDTH'(seed(Mode));
      illegal_d = 1'b1;
    end else if (Enable) begin
      count_d = WIDTH'(step(MAX_W'(count_q), WIDTH, mode_q, Dir));
      wrap_d = Dir == DIR_DOWN ? Position == '0 : Position == last_pos;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= WIDTH'(seed(Mode));
      mode_q <= Mode;
      wrap_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      count_q <= count_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
      illegal_q <= illegal_d;
    end
  end

  assign Count_out = count_q;
  assign Wrap = wrap_q;
  assign Illegal = illegal_q;
endmodule
